// File: rtl/flash_loader.sv
// Byte-stream loader: packs N/8 little-endian bytes per word and writes a
// 4-word frame into a small word store, pulsing o_frame_done after the last write.
module flash_loader #(
    parameter int N = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [7:0]   i_byte,
    input  logic         i_byte_valid,
    output logic         o_byte_ready,
    output logic [N-1:0] o_word,
    output logic         o_write_enable,
    output logic [1:0]   o_address,
    output logic         o_busy,
    output logic         o_frame_done
);

    localparam int BPW = N / 8;

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t         state, state_d;
    logic [1:0]     cnt, cnt_d;
    logic [1:0]     addr_d;
    logic [N-1:0]   asm_q, asm_d;
    logic [N-1:0]   word_d;
    logic           we_d, done_d;
    logic           accept;

    // Abort masks ready so no byte slips in on the cycle the frame is cancelled.
    assign o_byte_ready = (state == COLLECT) && !i_abort;
    assign accept       = o_byte_ready && i_byte_valid;
    assign o_busy       = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = o_address;
        asm_d   = asm_q;
        word_d  = o_word;
        we_d    = 1'b0;
        done_d  = 1'b0;
        if (i_abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state_d = COLLECT;
                        cnt_d   = 2'd0;
                        addr_d  = 2'd0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int k = 0; k < BPW; k++)
                            if (cnt == 2'(k)) asm_d[8*k +: 8] = i_byte;
                        // Strobe and word are launched here so they are flop
                        // outputs for the whole WRITE cycle.
                        if (cnt == 2'(BPW - 1)) begin
                            state_d = WRITE;
                            word_d  = asm_d;
                            we_d    = 1'b1;
                            cnt_d   = 2'd0;
                        end else begin
                            cnt_d = cnt + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (o_address == 2'd3) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = o_address + 2'd1;
                        cnt_d   = 2'd0;
                        state_d = COLLECT;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            o_address      <= 2'd0;
            asm_q          <= '0;
            o_word         <= '0;
            o_write_enable <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            o_address      <= addr_d;
            asm_q          <= asm_d;
            o_word         <= word_d;
            o_write_enable <= we_d;
            o_frame_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench for flash_loader: N=16 and N=32 instances, directed frames,
// monitors pop expected write/done events whenever the DUT strobes.
module tb_flash_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, v16, v32;
    logic [7:0]  byte_in;
    logic        r16, we16, busy16, fd16;
    logic [15:0] word16;
    logic [1:0]  addr16;
    logic        r32, we32, busy32, fd32;
    logic [31:0] word32;
    logic [1:0]  addr32;

    flash_loader #(.N(16)) u16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_byte(byte_in), .i_byte_valid(v16), .o_byte_ready(r16),
        .o_word(word16), .o_write_enable(we16), .o_address(addr16),
        .o_busy(busy16), .o_frame_done(fd16)
    );

    flash_loader #(.N(32)) u32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_byte(byte_in), .i_byte_valid(v32), .o_byte_ready(r32),
        .o_word(word32), .o_write_enable(we32), .o_address(addr32),
        .o_busy(busy32), .o_frame_done(fd32)
    );

    typedef struct {
        bit          done;
        logic [1:0]  addr;
        logic [31:0] word;
    } ev_t;

    ev_t q16[$];
    ev_t q32[$];
    ev_t e16, e32;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we16) begin
                chk("ready_low_in_write16", 32'(r16), 32'd0);
                if (q16.size() == 0) chk("event_expected16", 32'(q16.size()), 32'd1);
                else begin
                    e16 = q16.pop_front();
                    chk("kind_write16", 32'(e16.done), 32'd0);
                    chk("addr16", 32'(addr16), 32'(e16.addr));
                    chk("word16", 32'(word16), e16.word);
                end
            end
            if (fd16) begin
                if (q16.size() == 0) chk("event_expected16", 32'(q16.size()), 32'd1);
                else begin
                    e16 = q16.pop_front();
                    chk("kind_done16", 32'(e16.done), 32'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (we32) begin
                chk("ready_low_in_write32", 32'(r32), 32'd0);
                if (q32.size() == 0) chk("event_expected32", 32'(q32.size()), 32'd1);
                else begin
                    e32 = q32.pop_front();
                    chk("kind_write32", 32'(e32.done), 32'd0);
                    chk("addr32", 32'(addr32), 32'(e32.addr));
                    chk("word32", word32, e32.word);
                end
            end
            if (fd32) begin
                if (q32.size() == 0) chk("event_expected32", 32'(q32.size()), 32'd1);
                else begin
                    e32 = q32.pop_front();
                    chk("kind_done32", 32'(e32.done), 32'd1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit sel, input bit gap);
        bit ok = 1'b0;
        byte_in = b;
        if (sel) v32 = 1'b1; else v16 = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (sel ? r32 : r16) begin
                tick(1);
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        v16 = 1'b0;
        v32 = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
        if (gap) tick(1);
    endtask

    task automatic push_w16(input logic [1:0] a, input logic [15:0] w);
        q16.push_back('{done: 1'b0, addr: a, word: {16'h0, w}});
    endtask

    task automatic push_done16();
        q16.push_back('{done: 1'b1, addr: 2'd0, word: 32'h0});
    endtask

    // Bytes f..f+7 pack into four little-endian 16-bit words.
    task automatic push_frame16(input logic [7:0] f);
        for (int k = 0; k < 4; k++) begin
            logic [7:0] lo, hi;
            lo = f + 8'(2 * k);
            hi = lo + 8'd1;
            push_w16(2'(k), {hi, lo});
        end
        push_done16();
    endtask

    task automatic send_frame16(input logic [7:0] f, input bit gap);
        for (int i = 0; i < 8; i++) send(f + 8'(i), 1'b0, gap);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        byte_in = 8'h00; v16 = 1'b0; v32 = 1'b0;
        tick(2);
        chk("rst_word", 32'(word16), 32'd0);
        chk("rst_we", 32'(we16), 32'd0);
        chk("rst_addr", 32'(addr16), 32'd0);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(fd16), 32'd0);
        chk("rst_ready", 32'(r16), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Back-to-back frame with literal expected words
        push_w16(2'd0, 16'h0201);
        push_w16(2'd1, 16'h0403);
        push_w16(2'd2, 16'h0605);
        push_w16(2'd3, 16'h0807);
        push_done16();
        do_start();
        chk("busy_after_start", 32'(busy16), 32'd1);
        send_frame16(8'h01, 1'b0);
        tick(3);
        chk("busy_after_frame", 32'(busy16), 32'd0);
        chk("q_drained_frame1", 32'(q16.size()), 32'd0);

        // Same frame with valid toggling
        push_frame16(8'h01);
        do_start();
        send_frame16(8'h01, 1'b1);
        tick(3);
        chk("busy_after_gapped", 32'(busy16), 32'd0);
        chk("q_drained_gapped", 32'(q16.size()), 32'd0);

        // Abort on the 2nd byte of word 1
        push_w16(2'd0, 16'h0201);
        do_start();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        byte_in = 8'h04; v16 = 1'b1; abort = 1'b1;
        #3;
        chk("ready_low_on_abort", 32'(r16), 32'd0);
        tick(1);
        abort = 1'b0; v16 = 1'b0;
        chk("idle_after_abort", 32'(busy16), 32'd0);
        tick(4);
        chk("q_after_abort", 32'(q16.size()), 32'd0);
        push_frame16(8'h11);
        do_start();
        send_frame16(8'h11, 1'b0);
        tick(3);
        chk("busy_after_restart", 32'(busy16), 32'd0);

        // Start pulsed mid-frame during word 2
        push_frame16(8'h01);
        do_start();
        for (int i = 0; i < 5; i++) send(8'h01 + 8'(i), 1'b0, 1'b0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 5; i < 8; i++) send(8'h01 + 8'(i), 1'b0, 1'b0);
        tick(3);
        chk("busy_after_ignored_start", 32'(busy16), 32'd0);
        chk("addr_holds_last", 32'(addr16), 32'd3);

        // Start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy16), 32'd0);

        // Async reset after 3 bytes
        push_w16(2'd0, 16'h0201);
        do_start();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_word", 32'(word16), 32'd0);
        chk("arst_addr", 32'(addr16), 32'd0);
        chk("arst_we", 32'(we16), 32'd0);
        chk("arst_done", 32'(fd16), 32'd0);
        chk("arst_busy", 32'(busy16), 32'd0);
        chk("arst_ready", 32'(r16), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        byte_in = 8'h55; v16 = 1'b1;
        tick(6);
        v16 = 1'b0;
        chk("idle_after_reset", 32'(busy16), 32'd0);
        push_frame16(8'h21);
        do_start();
        send_frame16(8'h21, 1'b0);
        tick(3);
        chk("busy_after_reset_frame", 32'(busy16), 32'd0);

        // N=32 frame: AA BB CC DD repeated
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        for (int k = 0; k < 4; k++)
            q32.push_back('{done: 1'b0, addr: 2'(k), word: 32'hDDCCBBAA});
        q32.push_back('{done: 1'b1, addr: 2'd0, word: 32'h0});
        do_start();
        for (int k = 0; k < 4; k++) begin
            send(8'hAA, 1'b1, 1'b0);
            send(8'hBB, 1'b1, 1'b0);
            send(8'hCC, 1'b1, 1'b0);
            send(8'hDD, 1'b1, 1'b0);
        end
        tick(3);
        chk("busy32_after_frame", 32'(busy32), 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);

        chk("q16_empty", 32'(q16.size()), 32'd0);
        chk("q32_empty", 32'(q32.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
